mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares a single-ported unified memory between the core's instruction-fetch port and its data (load/store) port. Each port raises a request and holds it until granted. The arbiter picks one requester, issues exactly one memory transaction, and waits for its response before arbitrating again. It sits between the `riscv_core` fetch/data interfaces and the memory model or bus, so the core can run against one memory. Data accesses have priority, and a starvation guard guarantees forward progress for instruction fetch.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending (1..15)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low; 0 = reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch accepted by memory (one-cycle pulse)
- if_rvalid  out  1  fetch data valid (one-cycle pulse)
- if_rdata  out  DATA_WIDTH  fetch data
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_WIDTH/8  byte enables
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_gnt  out  1  data request accepted by memory (pulse)
- d_rvalid  out  1  load data / store acknowledge valid (pulse)
- d_rdata  out  DATA_WIDTH  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ready  in  1  memory accepts the request this cycle when mem_req=1
- mem_rvalid  in  1  memory response valid; one per accepted request, in order
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  state != IDLE
- proto_err  out  1  sticky: mem_rvalid seen outside RESP

## Operation
- FSM states: IDLE, REQ, RESP. Reset state is IDLE.
- **IDLE**
  - If any request is pending, latch the winner (owner) and its command fields into registers, then go to REQ.
  - With no request pending, stay in IDLE.
- **Arbitration (IDLE only)**
  - Data wins by default.
  - Fetch wins if if_req=1 and d_req=0, or if if_req=1 and starve_cnt == STARVE_LIMIT.
- **starve_cnt (4 bits)**
  - Increments on each data grant while if_req=1.
  - Clears on a fetch grant or in any cycle with if_req=0.
  - Saturates at STARVE_LIMIT.
- **REQ**
  - mem_req=1 and mem_we/be/addr/wdata driven from the latched registers. Fetch transactions drive mem_we=0 and mem_be all ones.
  - On mem_ready=1: pulse the owner's gnt in the same cycle (combinational: mem_req & mem_ready & owner), then go to RESP.
  - On mem_ready=0: hold, with fields stable.
- **RESP**
  - mem_req=0. On mem_rvalid=1: register mem_rdata into the owner's rdata and set the owner's rvalid for the next cycle, then go to IDLE.
  - Stores also receive d_rvalid; d_rdata then carries whatever mem_rdata held.
- The non-owner port never sees gnt or rvalid.
- if_rdata/d_rdata hold their last value until overwritten.
- **mem_rvalid in IDLE or REQ:** ignored (no rvalid to any port) and sets proto_err.
- Request inputs are sampled only in IDLE. Changes while a request is not yet granted are the requester's protocol violation and are not checked.
- **Reset (reset=0), including mid-transaction:**
  - FSM goes to IDLE; mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid, busy and proto_err go to 0.
  - if_rdata, d_rdata, latched fields and starve_cnt go to 0.
  - In-flight responses are discarded. A mem_rvalid arriving after reset sets proto_err (verification must tolerate this).

## Timing
- Request seen in IDLE at cycle N gives mem_req=1 at N+1.
- With mem_ready=1 at N+1, gnt pulses at N+1.
- mem_rvalid at cycle M gives x_rvalid=1 and x_rdata valid at M+1. The FSM is IDLE at M+1 and may arbitrate in that cycle.
- Minimum request-to-rvalid latency is 3 cycles (memory responds the cycle after accept). Maximum throughput is one transaction per 3 cycles.
- A requester may keep req high after gnt to request again. It is re-arbitrated at the next IDLE, the same cycle its rvalid pulses.
- busy=1 in REQ and RESP.
- gnt is the only combinational output. All other outputs are registered or decoded from state and registers.

## Test plan
- **Single load.** d_req, d_we=0, d_addr=0x100; mem_ready=1, mem_rvalid next cycle with mem_rdata=0xDEADBEEF.
  - Expect: mem_req at N+1, d_gnt at N+1, d_rvalid=1 and d_rdata=0xDEADBEEF at N+3.
  - Expect: no if_gnt or if_rvalid at any point.
- **Simultaneous requests.** if_req and d_req in the same cycle.
  - Expect: data is granted first, with mem_addr=d_addr; fetch follows at the next IDLE with mem_we=0 and mem_be=0xF.
- **Starvation.** d_req held high with d_we=1 continuously and if_req held high, STARVE_LIMIT=4.
  - Expect: exactly 4 d_gnt pulses, then 1 if_gnt, then the pattern repeats.
- **Backpressure.** mem_ready=0 for 5 cycles during REQ.
  - Expect: mem_req and all fields stable, no gnt, busy=1; gnt pulses in the cycle mem_ready rises.
- **Reset mid-transaction.** reset=0 in RESP, then release, then mem_rvalid=1.
  - Expect: all outputs 0 during reset; after release, no rvalid to either port and proto_err=1.
- **Stray response.** mem_rvalid=1 in IDLE.
  - Expect: proto_err=1 and held until reset; no rvalid to either port.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the instruction-fetch and data ports.
// Data wins by default; a saturating starvation counter forces a fetch grant.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  // instruction-fetch port
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  // data port
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  // memory side
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  // status
  output logic                    busy,
  output logic                    proto_err
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = 4;
  localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state;
  logic                   owner_d;   // 1: data port owns the current transaction
  logic                   lat_we;
  logic [BE_WIDTH-1:0]    lat_be;
  logic [ADDR_WIDTH-1:0]  lat_addr;
  logic [DATA_WIDTH-1:0]  lat_wdata;
  logic [CNT_WIDTH-1:0]   starve_cnt;
  logic                   fetch_wins;
  logic                   accept;

  // Fetch wins when alone or once data has taken its allowed run of grants
  assign fetch_wins = if_req && (!d_req || (starve_cnt == STARVE_MAX));
  assign accept     = (state == REQ) && mem_ready;

  assign if_gnt    = accept && !owner_d;
  assign d_gnt     = accept && owner_d;
  assign mem_req   = (state == REQ);
  assign busy      = (state != IDLE);
  assign mem_we    = lat_we;
  assign mem_be    = lat_be;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      starve_cnt <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      proto_err  <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;

      // A response with no accepted request outstanding is a memory protocol error
      if (mem_rvalid && (state != RESP)) begin
        proto_err <= 1'b1;
      end

      if (!if_req || if_gnt) begin
        starve_cnt <= '0;
      end else if (d_gnt && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            owner_d <= !fetch_wins;
            if (fetch_wins) begin
              lat_we    <= 1'b0;
              lat_be    <= '1;
              lat_addr  <= if_addr;
              lat_wdata <= '0;
            end else begin
              lat_we    <= d_we;
              lat_be    <= d_be;
              lat_addr  <= d_addr;
              lat_wdata <= d_wdata;
            end
            state <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid) begin
            if (owner_d) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand sequences
// for multi-cycle corners, and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          busy, proto_err;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_mem_req"}, mem_req, 1'b0);
    chk1({tag, "_if_gnt"}, if_gnt, 1'b0);
    chk1({tag, "_d_gnt"}, d_gnt, 1'b0);
    chk1({tag, "_if_rvalid"}, if_rvalid, 1'b0);
    chk1({tag, "_d_rvalid"}, d_rvalid, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_proto_err"}, proto_err, 1'b0);
    chk32({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk32({tag, "_d_rdata"}, d_rdata, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic        if_req, d_req, ready, rvalid;
    logic [31:0] rdata;
    logic        e_mem_req, e_if_gnt, e_d_gnt, e_if_rvalid, e_d_rvalid, e_busy;
    logic [31:0] e_addr, e_rdata;
  } vec_t;

  vec_t tbl[11];

  // transaction-level reference model state
  bit          m_has, m_acc, m_port_d, m_rv_if, m_rv_d;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  int          m_starve, resp_wait;
  bit          if_done, d_done;

  initial begin
    reset = 1'b0;
    clear_inputs();

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    // single load, then simultaneous fetch+data requests
    //           if d  rdy rv rdata          mreq ig dg irv drv busy addr      rdata
    tbl[0]  = '{0, 1, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0, 32'h0,   32'h0};
    tbl[1]  = '{0, 1, 1, 0, 32'h0,          1, 0, 1, 0, 0, 1, 32'h100, 32'h0};
    tbl[2]  = '{0, 0, 1, 1, 32'hDEADBEEF,   0, 0, 0, 0, 0, 1, 32'h0,   32'h0};
    tbl[3]  = '{0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 1, 0, 32'h0,   32'hDEADBEEF};
    tbl[4]  = '{1, 1, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0, 32'h0,   32'h0};
    tbl[5]  = '{1, 1, 1, 0, 32'h0,          1, 0, 1, 0, 0, 1, 32'h100, 32'h0};
    tbl[6]  = '{1, 0, 1, 1, 32'h11111111,   0, 0, 0, 0, 0, 1, 32'h0,   32'h0};
    tbl[7]  = '{1, 0, 1, 0, 32'h0,          0, 0, 0, 0, 1, 0, 32'h0,   32'h11111111};
    tbl[8]  = '{1, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 1, 32'h200, 32'h0};
    tbl[9]  = '{0, 0, 1, 1, 32'h22222222,   0, 0, 0, 0, 0, 1, 32'h0,   32'h0};
    tbl[10] = '{0, 0, 1, 0, 32'h0,          0, 0, 0, 1, 0, 0, 32'h0,   32'h22222222};

    if_addr = 32'h200; d_addr = 32'h100; d_we = 1'b0; d_be = 4'hF; d_wdata = 32'h0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if_req = tbl[i].if_req; d_req = tbl[i].d_req;
      mem_ready = tbl[i].ready; mem_rvalid = tbl[i].rvalid; mem_rdata = tbl[i].rdata;
      #1;
      chk1($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].e_mem_req);
      chk1($sformatf("tbl%0d_if_gnt", i), if_gnt, tbl[i].e_if_gnt);
      chk1($sformatf("tbl%0d_d_gnt", i), d_gnt, tbl[i].e_d_gnt);
      chk1($sformatf("tbl%0d_if_rvalid", i), if_rvalid, tbl[i].e_if_rvalid);
      chk1($sformatf("tbl%0d_d_rvalid", i), d_rvalid, tbl[i].e_d_rvalid);
      chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_mem_req) chk32($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
      if (tbl[i].e_if_gnt) begin
        chk1($sformatf("tbl%0d_fetch_we", i), mem_we, 1'b0);
        chk32($sformatf("tbl%0d_fetch_be", i), 32'(mem_be), 32'hF);
      end
      if (tbl[i].e_d_rvalid) chk32($sformatf("tbl%0d_d_rdata", i), d_rdata, tbl[i].e_rdata);
      if (tbl[i].e_if_rvalid) chk32($sformatf("tbl%0d_if_rdata", i), if_rdata, tbl[i].e_rdata);
    end

    // starvation guard: four data grants then one fetch grant, repeating
    begin
      int  n_gnt;
      bit  gnt_prev;
      bit  exp_fetch;
      n_gnt = 0; gnt_prev = 1'b0;
      @(negedge clk);
      clear_inputs();
      d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h40; d_wdata = 32'h1234;
      if_req = 1'b1; if_addr = 32'h400; mem_ready = 1'b1;
      for (int c = 0; c < 60 && n_gnt < 10; c++) begin
        @(negedge clk);
        mem_rvalid = gnt_prev;
        #1;
        gnt_prev = if_gnt | d_gnt;
        if (if_gnt | d_gnt) begin
          exp_fetch = ((n_gnt % 5) == 4);
          chk1($sformatf("starve_gnt%0d_is_fetch", n_gnt), if_gnt, exp_fetch);
          chk1($sformatf("starve_gnt%0d_is_data", n_gnt), d_gnt, !exp_fetch);
          n_gnt++;
        end
      end
      chk32("starve_grant_count", 32'(n_gnt), 32'd10);
      @(negedge clk);
      clear_inputs();
      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      chk1("starve_drain_if_rvalid", if_rvalid, 1'b1);
    end

    // backpressure: mem_ready low for five REQ cycles
    @(negedge clk);
    clear_inputs();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h340; d_wdata = 32'hCAFEF00D;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk1($sformatf("bp%0d_mem_req", c), mem_req, 1'b1);
      chk1($sformatf("bp%0d_d_gnt", c), d_gnt, 1'b0);
      chk1($sformatf("bp%0d_busy", c), busy, 1'b1);
      chk32($sformatf("bp%0d_addr", c), mem_addr, 32'h340);
      chk1($sformatf("bp%0d_we", c), mem_we, 1'b1);
      chk32($sformatf("bp%0d_be", c), 32'(mem_be), 32'h3);
      chk32($sformatf("bp%0d_wdata", c), mem_wdata, 32'hCAFEF00D);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk1("bp_gnt_on_ready", d_gnt, 1'b1);
    @(negedge clk);
    d_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk1("bp_store_ack", d_rvalid, 1'b1);
    chk32("bp_store_rdata", d_rdata, 32'h5A5A5A5A);

    // reset while in RESP, then a late response
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    d_req = 1'b0; mem_ready = 1'b0;
    #1;
    chk1("rst_mid_in_resp", busy, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("rst_mid");
    chk32("rst_mid_addr", mem_addr, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk1("rst_late_if_rvalid", if_rvalid, 1'b0);
    chk1("rst_late_d_rvalid", d_rvalid, 1'b0);
    chk1("rst_late_proto_err", proto_err, 1'b1);

    // stray responses in IDLE and in REQ; proto_err is sticky until reset
    do_reset();
    #1;
    chk1("stray_clear_after_reset", proto_err, 1'b0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h99;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      chk1($sformatf("stray_idle_perr%0d", c), proto_err, 1'b1);
      chk1($sformatf("stray_idle_rv%0d", c), if_rvalid | d_rvalid, 1'b0);
    end
    do_reset();
    d_req = 1'b1; d_addr = 32'h10;
    @(negedge clk);
    d_req = 1'b0; mem_rvalid = 1'b1;
    #1;
    chk1("stray_req_in_req", mem_req, 1'b1);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk1("stray_req_perr", proto_err, 1'b1);
    chk1("stray_req_still_req", mem_req, 1'b1);
    chk1("stray_req_rv", if_rvalid | d_rvalid, 1'b0);

    // randomized traffic against the transaction model
    do_reset();
    m_has = 0; m_acc = 0; m_port_d = 0; m_rv_if = 0; m_rv_d = 0;
    m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
    m_if_rdata = '0; m_d_rdata = '0; m_starve = 0; resp_wait = 0;
    if_done = 0; d_done = 0;
    for (int c = 0; c < 3000; c++) begin
      logic e_mreq, e_ig, e_dg;
      bit   fetch_first;
      @(negedge clk);
      if (if_done) begin
        if_req = ($urandom_range(0, 1) == 1);
        if_addr = $urandom;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (d_done || (!d_req && $urandom_range(0, 2) == 0)) begin
        d_req = d_done ? ($urandom_range(0, 1) == 1) : 1'b1;
        d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(0, 15));
        d_addr = $urandom; d_wdata = $urandom;
      end
      if_done = 0; d_done = 0;
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rvalid = m_has && m_acc && (resp_wait == 0);
      mem_rdata = $urandom;
      #1;
      e_mreq = m_has && !m_acc;
      e_ig = e_mreq && mem_ready && !m_port_d;
      e_dg = e_mreq && mem_ready && m_port_d;
      chk1("rnd_mem_req", mem_req, e_mreq);
      chk1("rnd_busy", busy, m_has);
      chk1("rnd_if_gnt", if_gnt, e_ig);
      chk1("rnd_d_gnt", d_gnt, e_dg);
      chk1("rnd_if_rvalid", if_rvalid, m_rv_if);
      chk1("rnd_d_rvalid", d_rvalid, m_rv_d);
      chk32("rnd_if_rdata", if_rdata, m_if_rdata);
      chk32("rnd_d_rdata", d_rdata, m_d_rdata);
      chk1("rnd_proto_err", proto_err, 1'b0);
      if (e_mreq) begin
        chk32("rnd_mem_addr", mem_addr, m_addr);
        chk1("rnd_mem_we", mem_we, m_we);
        chk32("rnd_mem_be", 32'(mem_be), 32'(m_be));
        if (m_port_d) chk32("rnd_mem_wdata", mem_wdata, m_wdata);
      end
      // advance the model across the coming clock edge
      m_rv_if = 0; m_rv_d = 0;
      fetch_first = if_req && (!d_req || m_starve >= int'(LIMIT));
      if (m_has && m_acc) begin
        if (mem_rvalid) begin
          if (m_port_d) begin m_rv_d = 1; m_d_rdata = mem_rdata; end
          else begin m_rv_if = 1; m_if_rdata = mem_rdata; end
          m_has = 0;
        end else begin
          resp_wait--;
        end
      end else if (m_has) begin
        if (mem_ready) begin m_acc = 1; resp_wait = $urandom_range(0, 3); end
      end else if (if_req || d_req) begin
        m_has = 1; m_acc = 0; m_port_d = !fetch_first;
        if (fetch_first) begin
          m_we = 0; m_be = 4'hF; m_addr = if_addr; m_wdata = '0;
        end else begin
          m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
        end
      end
      if (!if_req || e_ig) m_starve = 0;
      else if (e_dg && m_starve < int'(LIMIT)) m_starve++;
      if_done = e_ig;
      d_done = e_dg;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
